// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath control FSM with retire counter
module multicycle_control (
  input  logic        clk,
  input  logic        arst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_2_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal_op,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  assign state = state_q;

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control decode; write-type strobes are squashed during reset.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_2_reg  = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (arst) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      pc_write_cond = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      instr_count <= 32'd0;
    end else if (instr_done) begin
      instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        arst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_2_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [31:0] instr_count;

  multicycle_control dut (
    .clk(clk), .arst(arst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    int         lat;
    int         n_memw;
    int         n_regw;
    int         n_irw;
    bit         legal;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] model_cnt = 32'd0;
  bit          mon_en = 1'b0;
  int          cyc = 0;
  int          c_memw = 0, c_regw = 0, c_irw = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Retirement-cycle signature:
  // {state, reg_write, mem_2_reg, reg_dst, mem_write, pc_write, pc_write_cond, alu_op, pc_source, instr_done, illegal_op}
  function automatic logic [15:0] sig_of(input logic [5:0] op);
    case (op)
      6'h23:   sig_of = {4'd4,  6'b110000, 2'b00, 2'b00, 2'b10};
      6'h2B:   sig_of = {4'd5,  6'b000100, 2'b00, 2'b00, 2'b10};
      6'h00:   sig_of = {4'd7,  6'b101000, 2'b00, 2'b00, 2'b10};
      6'h08:   sig_of = {4'd10, 6'b100000, 2'b00, 2'b00, 2'b10};
      6'h04:   sig_of = {4'd8,  6'b000001, 2'b01, 2'b01, 2'b10};
      6'h02:   sig_of = {4'd11, 6'b000010, 2'b00, 2'b10, 2'b10};
      default: sig_of = {4'd1,  6'b000000, 2'b00, 2'b00, 2'b01};
    endcase
  endfunction

  function automatic int base_lat(input logic [5:0] op);
    case (op)
      6'h23:   base_lat = 5;
      6'h2B, 6'h00, 6'h08: base_lat = 4;
      6'h04, 6'h02: base_lat = 3;
      default: base_lat = 2;
    endcase
  endfunction

  function automatic bit is_mem(input logic [5:0] op);
    is_mem = (op == 6'h23) || (op == 6'h2B);
  endfunction

  // Monitor: accumulate per-instruction activity and score each retirement.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      cyc++;
      c_memw += int'(mem_write);
      c_regw += int'(reg_write);
      c_irw  += int'(ir_write);
      if (instr_done || illegal_op) begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("latency", cyc, e.lat);
          check("signature",
                {16'h0, state, reg_write, mem_2_reg, reg_dst, mem_write, pc_write,
                 pc_write_cond, alu_op, pc_source, instr_done, illegal_op},
                {16'h0, sig_of(e.op)});
          check("mem_write_cycles", c_memw, e.n_memw);
          check("reg_write_cycles", c_regw, e.n_regw);
          check("ir_write_cycles", c_irw, e.n_irw);
          check("instr_count", instr_count, model_cnt);
          if (e.legal) model_cnt = model_cnt + 32'd1;
        end
        cyc = 0; c_memw = 0; c_regw = 0; c_irw = 0;
      end
    end
  end

  // Drive one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    exp_t e;
    bit   mem;
    mem      = is_mem(op);
    e.op     = op;
    e.legal  = (base_lat(op) != 2);
    e.lat    = base_lat(op) + fw + (mem ? mw : 0);
    e.n_memw = (op == 6'h2B) ? mw + 1 : 0;
    e.n_regw = (op == 6'h23 || op == 6'h00 || op == 6'h08) ? 1 : 0;
    e.n_irw  = 1;
    sb_q.push_back(e);
    for (int k = 0; k < e.lat; k++) begin
      opcode    = (k <= fw) ? 6'($urandom) : op;
      mem_ready = !((k < fw) || (mem && k >= fw + 3 && k < fw + 3 + mw));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    arst      = 1'b0;
    model_cnt = 32'd0;
    cyc = 0; c_memw = 0; c_regw = 0; c_irw = 0;
    mon_en    = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [8];
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h04; ops[3] = 6'h02;
    ops[4] = 6'h23; ops[5] = 6'h2B; ops[6] = 6'h3F; ops[7] = 6'h11;

    arst = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
    #12;
    check("reset_state", {28'h0, state}, 32'd0);
    check("reset_count", instr_count, 32'd0);
    check("reset_strobes", {25'h0, pc_write, ir_write, pc_write_cond, reg_write,
                            mem_write, instr_done, illegal_op}, 32'd0);
    release_reset();

    run_instr(6'h23, 0, 0);
    run_instr(6'h2B, 0, 3);
    run_instr(6'h00, 0, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h00, 5, 0);

    force dut.instr_count = 32'hFFFFFFFF;
    #1;
    release dut.instr_count;
    model_cnt = 32'hFFFFFFFF;
    run_instr(6'h02, 0, 0);
    run_instr(6'h04, 0, 0);

    for (int i = 0; i < 150; i++) begin
      run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3));
    end
    check("queue_drained", sb_q.size(), 32'd0);

    mon_en    = 1'b0;
    opcode    = 6'h23;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_memrd", {28'h0, state}, 32'd3);
    arst      = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("async_reset_state", {28'h0, state}, 32'd0);
    check("async_reset_count", instr_count, 32'd0);
    check("async_reset_strobes", {25'h0, pc_write, ir_write, pc_write_cond, reg_write,
                                  mem_write, instr_done, illegal_op}, 32'd0);
    release_reset();
    run_instr(6'h02, 0, 0);
    run_instr(6'h23, 1, 2);
    @(negedge clk);
    check("final_count", instr_count, model_cnt);
    check("final_queue", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; state encoding and opcodes are fixed by this document.
REQ-002 Port: clk  in  1  system clock, all state changes on rising edge.
REQ-003 Port: arst  in  1  reset, asynchronous, active-high.
REQ-004 Port: opcode  in  6  instruction[31:26] from the external instruction register, valid from DECODE onward.
REQ-005 Port: mem_ready  in  1  memory handshake, high when the current read/write completes this cycle.
REQ-006 Ports (out, 1 bit each): pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_2_reg, reg_dst, reg_write, alu_src_a.
REQ-007 Ports (out, 2 bits each): alu_src_b (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2), alu_op (00 add, 01 sub, 10 R-type funct), pc_source (00 ALU result, 01 ALUOut, 10 jump target).
REQ-008 Port: state  out  4  current state, debug.
REQ-009 Port: instr_done  out  1  one-cycle pulse in the final cycle of each retired instruction.
REQ-010 Port: illegal_op  out  1  high in the DECODE cycle when opcode is unsupported.
REQ-011 Port: instr_count  out  32  retired-instruction counter.

Function
REQ-012 Supported opcodes: R-type 6'h00, ADDI 6'h08, BEQ 6'h04, J 6'h02, LW 6'h23, SW 6'h2B.
REQ-013 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge with all outputs 0.
REQ-014 The state register is the only control storage; outputs decode from state combinationally, plus mem_ready where stated.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=pc_write=mem_ready; hold while mem_ready=0, else go to DECODE.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state LW/SW->MEMADR, R->EXEC, ADDI->ADDIEX, BEQ->BRANCH, J->JUMP, other->FETCH with illegal_op=1.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; LW->MEMRD, SW->MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then go to MEMWB.
REQ-019 MEMWB: reg_dst=0, mem_2_reg=1, reg_write=1, instr_done=1; next state FETCH.
REQ-020 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1; instr_done=mem_ready; then go to FETCH.
REQ-021 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB.
REQ-022 ALUWB: reg_dst=1, mem_2_reg=0, reg_write=1, instr_done=1; next state FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
REQ-024 ADDIWB: reg_dst=0, mem_2_reg=0, reg_write=1, instr_done=1; next state FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1; next state FETCH.
REQ-026 JUMP: pc_source=10, pc_write=1, instr_done=1; next state FETCH.
REQ-027 Every output not listed for a state is 0 in that state.
REQ-028 Latency with mem_ready tied high is LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3 cycles; each wait cycle adds 1 cycle.
REQ-029 instr_count increments by 1 on each edge where instr_done=1, wraps from 32'hFFFFFFFF to 0, and does not count illegal opcodes.
REQ-030 opcode changes outside DECODE/MEMADR sampling have no effect; the next state depends on opcode only in DECODE and MEMADR.

Reset
REQ-031 arst=1 immediately sets state=FETCH and instr_count=0, independent of clk.
REQ-032 While arst=1, pc_write, ir_write, pc_write_cond, reg_write, mem_write, instr_done and illegal_op are forced 0.
REQ-033 Reset in any state, including mid-wait, abandons the instruction without a count; the first edge after release evaluates FETCH.

Verification
REQ-034 Reset, then LW (6'h23) with mem_ready=1 -> states 0,1,2,3,4; reg_write=1 with mem_2_reg=1 in cycle 5; instr_count=1.
REQ-035 SW with mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, instr_done pulses once on the ready cycle, and there is no reg_write.
REQ-036 R, ADDI, BEQ, J back-to-back with ready high -> 14 cycles total, instr_count=4, and alu_op/pc_source per REQ-021..026.
REQ-037 Opcode 6'h3F -> illegal_op=1 in DECODE, next state FETCH, and instr_count unchanged.
REQ-038 FETCH with mem_ready=0 for 5 cycles -> ir_write=pc_write=0 throughout, then pulse 1 cycle; also preload count 32'hFFFFFFFF, retire one instruction -> 0.
REQ-039 Assert arst mid-MEMRD -> state=0 asynchronously, write-enables 0, instr_count=0.
